// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX stage: ALU op codes, control-bundle bit
// positions and default widths.
package id_ex_stage_pkg;

    localparam int REG_AW = 5;
    localparam int CTRL_W = 7;

    // Bit positions inside ctrl = {reg_write, mem_read, mem_write, mem_to_reg, branch, alu_src, reg_dst}
    localparam int CTRL_REG_DST    = 0;
    localparam int CTRL_ALU_SRC    = 1;
    localparam int CTRL_BRANCH     = 2;
    localparam int CTRL_MEM_TO_REG = 3;
    localparam int CTRL_MEM_WRITE  = 4;
    localparam int CTRL_MEM_READ   = 5;
    localparam int CTRL_REG_WRITE  = 6;

    typedef enum logic [3:0] {
        ALU_AND  = 4'd0,
        ALU_OR   = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SRLV = 4'd3,
        ALU_SRL  = 4'd4,
        ALU_LUI  = 4'd5,
        ALU_SUB  = 4'd6,
        ALU_SLT  = 4'd7,
        ALU_ORI  = 4'd8,
        ALU_EQ   = 4'd9
    } aluctl_e;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID-side inputs, writeback-candidate inputs and EX-side outputs of the ID/EX stage.
// slave = the stage itself, master = whoever drives ID and observes EX.
interface id_ex_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = id_ex_stage_pkg::REG_AW,
    parameter int CTRL_W = id_ex_stage_pkg::CTRL_W
);
    logic              valid_i;
    logic [DATA_W-1:0] rs_data_i;
    logic [DATA_W-1:0] rt_data_i;
    logic [DATA_W-1:0] imm_i;
    logic [REG_AW-1:0] rs_i;
    logic [REG_AW-1:0] rt_i;
    logic [REG_AW-1:0] rd_i;
    logic [4:0]        shamt_i;
    logic [3:0]        aluctl_i;
    logic [CTRL_W-1:0] ctrl_i;
    logic              flush_i;
    logic              exm_we_i;
    logic [REG_AW-1:0] exm_wa_i;
    logic [DATA_W-1:0] exm_data_i;
    logic              wb_we_i;
    logic [REG_AW-1:0] wb_wa_i;
    logic [DATA_W-1:0] wb_data_i;

    logic              stall_o;
    logic              valid_o;
    logic [DATA_W-1:0] a_o;
    logic [DATA_W-1:0] b_o;
    logic [3:0]        aluctl_o;
    logic [4:0]        shamt_o;
    logic [REG_AW-1:0] wa_o;
    logic [DATA_W-1:0] st_data_o;
    logic [CTRL_W-1:0] ctrl_o;

    modport slave (
        input  valid_i, rs_data_i, rt_data_i, imm_i, rs_i, rt_i, rd_i, shamt_i,
               aluctl_i, ctrl_i, flush_i, exm_we_i, exm_wa_i, exm_data_i,
               wb_we_i, wb_wa_i, wb_data_i,
        output stall_o, valid_o, a_o, b_o, aluctl_o, shamt_o, wa_o, st_data_o, ctrl_o
    );

    modport master (
        output valid_i, rs_data_i, rt_data_i, imm_i, rs_i, rt_i, rd_i, shamt_i,
               aluctl_i, ctrl_i, flush_i, exm_we_i, exm_wa_i, exm_data_i,
               wb_we_i, wb_wa_i, wb_data_i,
        input  stall_o, valid_o, a_o, b_o, aluctl_o, shamt_o, wa_o, st_data_o, ctrl_o
    );

endinterface

// File: rtl/id_ex_stage_fwd_unit.sv
// Priority operand forwarding for one source register: EX/MEM over MEM/WB over
// register-file data; register 0 is never forwarded.
module id_ex_stage_fwd_unit #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] i_src_addr,
    input  logic [DATA_W-1:0] i_rf_data,
    input  logic              i_exm_we,
    input  logic [REG_AW-1:0] i_exm_wa,
    input  logic [DATA_W-1:0] i_exm_data,
    input  logic              i_wb_we,
    input  logic [REG_AW-1:0] i_wb_wa,
    input  logic [DATA_W-1:0] i_wb_data,
    output logic [DATA_W-1:0] o_data
);

    logic w_exm_hit;
    logic w_wb_hit;

    assign w_exm_hit = i_exm_we && (i_exm_wa != '0) && (i_exm_wa == i_src_addr);
    assign w_wb_hit  = i_wb_we  && (i_wb_wa  != '0) && (i_wb_wa  == i_src_addr);

    always_comb begin
        o_data = i_rf_data;
        if (w_exm_hit) begin
            o_data = i_exm_data;
        end else if (w_wb_hit) begin
            o_data = i_wb_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use bubble insertion.
// Optional macro ID_EX_STATS_EN adds saturating stall/flush cycle counters.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = id_ex_stage_pkg::REG_AW,
    parameter int CTRL_W = id_ex_stage_pkg::CTRL_W
) (
    input  logic  clk_i,
    input  logic  rst_i,
    id_ex_stage_if.slave bus
`ifdef ID_EX_STATS_EN
    ,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o
`endif
);

    import id_ex_stage_pkg::*;

    logic              w_hazard;
    logic              w_bubble;
    logic [DATA_W-1:0] w_fwd_rs;
    logic [DATA_W-1:0] w_fwd_rt;

    logic              r_vld_p1;
    logic [CTRL_W-1:0] r_ctrl_p1;
    aluctl_e           r_aluctl_p1;
    logic [4:0]        r_shamt_p1;
    logic [REG_AW-1:0] r_rs_p1;
    logic [REG_AW-1:0] r_rt_p1;
    logic [REG_AW-1:0] r_wa_p1;
    logic [DATA_W-1:0] r_rs_data_p1;
    logic [DATA_W-1:0] r_rt_data_p1;
    logic [DATA_W-1:0] r_imm_p1;

    // Load in EX whose result the ID instruction needs: the loaded value is not ready yet.
    assign w_hazard = bus.valid_i && r_vld_p1 && r_ctrl_p1[CTRL_MEM_READ] && (r_rt_p1 != '0)
                      && ((r_rt_p1 == bus.rs_i) || (r_rt_p1 == bus.rt_i));
    assign bus.stall_o = w_hazard && !bus.flush_i;
    assign w_bubble    = !bus.valid_i || bus.flush_i || w_hazard;

    // ---- ID -> EX register (p1) ----
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_vld_p1     <= 1'b0;
            r_ctrl_p1    <= '0;
            r_aluctl_p1  <= ALU_AND;
            r_shamt_p1   <= '0;
            r_rs_p1      <= '0;
            r_rt_p1      <= '0;
            r_wa_p1      <= '0;
            r_rs_data_p1 <= '0;
            r_rt_data_p1 <= '0;
            r_imm_p1     <= '0;
        end else begin
            r_vld_p1     <= !w_bubble;
            r_ctrl_p1    <= w_bubble ? '0 : bus.ctrl_i;
            r_aluctl_p1  <= w_bubble ? ALU_AND : aluctl_e'(bus.aluctl_i);
            r_shamt_p1   <= bus.shamt_i;
            r_rs_p1      <= bus.rs_i;
            r_rt_p1      <= bus.rt_i;
            r_wa_p1      <= bus.ctrl_i[CTRL_REG_DST] ? bus.rd_i : bus.rt_i;
            r_rs_data_p1 <= bus.rs_data_i;
            r_rt_data_p1 <= bus.rt_data_i;
            r_imm_p1     <= bus.imm_i;
        end
    end

    id_ex_stage_fwd_unit #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
        .i_src_addr (r_rs_p1),
        .i_rf_data  (r_rs_data_p1),
        .i_exm_we   (bus.exm_we_i),
        .i_exm_wa   (bus.exm_wa_i),
        .i_exm_data (bus.exm_data_i),
        .i_wb_we    (bus.wb_we_i),
        .i_wb_wa    (bus.wb_wa_i),
        .i_wb_data  (bus.wb_data_i),
        .o_data     (w_fwd_rs)
    );

    id_ex_stage_fwd_unit #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
        .i_src_addr (r_rt_p1),
        .i_rf_data  (r_rt_data_p1),
        .i_exm_we   (bus.exm_we_i),
        .i_exm_wa   (bus.exm_wa_i),
        .i_exm_data (bus.exm_data_i),
        .i_wb_we    (bus.wb_we_i),
        .i_wb_wa    (bus.wb_wa_i),
        .i_wb_data  (bus.wb_data_i),
        .o_data     (w_fwd_rt)
    );

    assign bus.valid_o   = r_vld_p1;
    assign bus.ctrl_o    = r_ctrl_p1;
    assign bus.aluctl_o  = r_aluctl_p1;
    assign bus.shamt_o   = r_shamt_p1;
    assign bus.wa_o      = r_wa_p1;
    assign bus.a_o       = w_fwd_rs;
    assign bus.b_o       = r_ctrl_p1[CTRL_ALU_SRC] ? r_imm_p1 : w_fwd_rt;
    assign bus.st_data_o = w_fwd_rt;

`ifdef ID_EX_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] val);
        return (val == 32'hFFFF_FFFF) ? val : val + 32'd1;
    endfunction

    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (bus.stall_o) r_stall_cnt <= sat_inc(r_stall_cnt);
            if (bus.flush_i) r_flush_cnt <= sat_inc(r_flush_cnt);
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, pass-through, forwarding, load-use and flush.
// Counter checks are compiled in when ID_EX_STATS_EN is defined.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    localparam logic [6:0] C_RTYPE = 7'b1000001; // reg_write, reg_dst
    localparam logic [6:0] C_ITYPE = 7'b1000010; // reg_write, alu_src
    localparam logic [6:0] C_LW    = 7'b1101010; // reg_write, mem_read, mem_to_reg, alu_src

    logic clk_i = 1'b0;
    logic rst_i;
    int   checks = 0;
    int   errors = 0;

    always #5 clk_i = ~clk_i;

    id_ex_stage_if #(.DATA_W(32), .REG_AW(5), .CTRL_W(7)) bus ();

`ifdef ID_EX_STATS_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    id_ex_stage #(.DATA_W(32), .REG_AW(5), .CTRL_W(7)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
`ifdef ID_EX_STATS_EN
        ,
        .stall_cnt_o (stall_cnt),
        .flush_cnt_o (flush_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        bus.valid_i    = 1'b0;
        bus.rs_data_i  = '0;
        bus.rt_data_i  = '0;
        bus.imm_i      = '0;
        bus.rs_i       = '0;
        bus.rt_i       = '0;
        bus.rd_i       = '0;
        bus.shamt_i    = '0;
        bus.aluctl_i   = '0;
        bus.ctrl_i     = '0;
        bus.flush_i    = 1'b0;
        bus.exm_we_i   = 1'b0;
        bus.exm_wa_i   = '0;
        bus.exm_data_i = '0;
        bus.wb_we_i    = 1'b0;
        bus.wb_wa_i    = '0;
        bus.wb_data_i  = '0;
    endtask

    task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
                         input aluctl_e alu, input logic [6:0] ctrl, input logic [4:0] sh);
        bus.valid_i   = 1'b1;
        bus.rs_i      = rs;
        bus.rt_i      = rt;
        bus.rd_i      = rd;
        bus.rs_data_i = rsd;
        bus.rt_data_i = rtd;
        bus.imm_i     = imm;
        bus.aluctl_i  = alu;
        bus.ctrl_i    = ctrl;
        bus.shamt_i   = sh;
    endtask

    initial begin
        rst_i = 1'b0;
        idle();
        #12;
        chk("rst_valid", bus.valid_o, 1'b0);
        chk("rst_ctrl", bus.ctrl_o, 7'd0);
        chk("rst_aluctl", bus.aluctl_o, 4'd0);
        chk("rst_wa", bus.wa_o, 5'd0);
        chk("rst_a", bus.a_o, 32'd0);
        chk("rst_b", bus.b_o, 32'd0);
        @(posedge clk_i);
        #1 rst_i = 1'b1;

        // R-type add, no forwarding
        issue(5'd1, 5'd2, 5'd4, 32'd5, 32'd7, 32'h100, ALU_ADD, C_RTYPE, 5'd3);
        #1 chk("pt_stall", bus.stall_o, 1'b0);
        tick();
        chk("pt_a", bus.a_o, 32'd5);
        chk("pt_b", bus.b_o, 32'd7);
        chk("pt_aluctl", bus.aluctl_o, 4'd2);
        chk("pt_valid", bus.valid_o, 1'b1);
        chk("pt_ctrl", bus.ctrl_o, C_RTYPE);
        chk("pt_wa_rd", bus.wa_o, 5'd4);
        chk("pt_shamt", bus.shamt_o, 5'd3);
        chk("pt_st", bus.st_data_o, 32'd7);

        // I-type: B from immediate, destination rt
        issue(5'd1, 5'd2, 5'd4, 32'd5, 32'd7, 32'h100, ALU_ORI, C_ITYPE, 5'd0);
        tick();
        chk("imm_b", bus.b_o, 32'h100);
        chk("imm_wa_rt", bus.wa_o, 5'd2);
        chk("imm_st", bus.st_data_o, 32'd7);
        chk("imm_aluctl", bus.aluctl_o, 4'd8);

        // Forward priority on rs=3
        issue(5'd3, 5'd2, 5'd5, 32'h11, 32'h22, 32'h0, ALU_ADD, C_RTYPE, 5'd0);
        tick();
        bus.exm_we_i = 1'b1; bus.exm_wa_i = 5'd3; bus.exm_data_i = 32'hAA;
        bus.wb_we_i  = 1'b1; bus.wb_wa_i  = 5'd3; bus.wb_data_i  = 32'hBB;
        #1 chk("fwd_exm_prio", bus.a_o, 32'hAA);
        bus.exm_we_i = 1'b0;
        #1 chk("fwd_wb", bus.a_o, 32'hBB);
        bus.wb_wa_i = 5'd2; bus.wb_data_i = 32'hCC;
        #1 chk("fwd_none_a", bus.a_o, 32'h11);
        chk("fwd_wb_b", bus.b_o, 32'hCC);
        chk("fwd_wb_st", bus.st_data_o, 32'hCC);
        bus.wb_we_i = 1'b0;
        #1 chk("fwd_rf_b", bus.b_o, 32'h22);

        // Register 0 is never forwarded
        issue(5'd0, 5'd2, 5'd5, 32'h33, 32'h22, 32'h0, ALU_ADD, C_RTYPE, 5'd0);
        tick();
        bus.exm_we_i = 1'b1; bus.exm_wa_i = 5'd0; bus.exm_data_i = 32'hFF;
        bus.wb_we_i  = 1'b1; bus.wb_wa_i  = 5'd0; bus.wb_data_i  = 32'hEE;
        #1 chk("zero_reg_a", bus.a_o, 32'h33);
        bus.exm_we_i = 1'b0; bus.wb_we_i = 1'b0;

        // Load-use: lw $9 then sub using rt=$9
        issue(5'd1, 5'd9, 5'd0, 32'h40, 32'h9, 32'd4, ALU_ADD, C_LW, 5'd0);
        tick();
        chk("lw_ctrl", bus.ctrl_o, C_LW);
        chk("lw_wa", bus.wa_o, 5'd9);
        issue(5'd2, 5'd9, 5'd10, 32'h1, 32'h2, 32'h0, ALU_SUB, C_RTYPE, 5'd0);
        #1 chk("lu_stall", bus.stall_o, 1'b1);
        tick();
        chk("lu_bubble_valid", bus.valid_o, 1'b0);
        chk("lu_bubble_ctrl", bus.ctrl_o, 7'd0);
        chk("lu_bubble_aluctl", bus.aluctl_o, 4'd0);
        chk("lu_stall_gone", bus.stall_o, 1'b0);
`ifdef ID_EX_STATS_EN
        chk("lu_stall_cnt", stall_cnt, 32'd1);
`endif
        tick();
        chk("lu_issue_valid", bus.valid_o, 1'b1);
        chk("lu_issue_aluctl", bus.aluctl_o, 4'd6);
        chk("lu_issue_wa", bus.wa_o, 5'd10);

        // Flush beats stall
        issue(5'd1, 5'd9, 5'd0, 32'h40, 32'h9, 32'd4, ALU_ADD, C_LW, 5'd0);
        tick();
        issue(5'd2, 5'd9, 5'd10, 32'h1, 32'h2, 32'h0, ALU_SUB, C_RTYPE, 5'd0);
        bus.flush_i = 1'b1;
        #1 chk("fl_stall", bus.stall_o, 1'b0);
        tick();
        chk("fl_valid", bus.valid_o, 1'b0);
        chk("fl_ctrl", bus.ctrl_o, 7'd0);
`ifdef ID_EX_STATS_EN
        chk("fl_flush_cnt", flush_cnt, 32'd1);
        chk("fl_stall_cnt", stall_cnt, 32'd1);
`endif
        bus.flush_i = 1'b0;

        // valid_i=0 loads a bubble
        bus.valid_i = 1'b0;
        tick();
        chk("inv_valid", bus.valid_o, 1'b0);
        chk("inv_ctrl", bus.ctrl_o, 7'd0);

        // Asynchronous reset mid-cycle with a valid instruction held
        issue(5'd1, 5'd2, 5'd4, 32'd5, 32'd7, 32'h100, ALU_ADD, C_RTYPE, 5'd3);
        tick();
        chk("pre_rst_valid", bus.valid_o, 1'b1);
        #2 rst_i = 1'b0;
        #1;
        chk("mid_rst_valid", bus.valid_o, 1'b0);
        chk("mid_rst_ctrl", bus.ctrl_o, 7'd0);
        chk("mid_rst_aluctl", bus.aluctl_o, 4'd0);
        chk("mid_rst_wa", bus.wa_o, 5'd0);
        chk("mid_rst_a", bus.a_o, 32'd0);
`ifdef ID_EX_STATS_EN
        chk("mid_rst_stall_cnt", stall_cnt, 32'd0);
        chk("mid_rst_flush_cnt", flush_cnt, 32'd0);
`endif
        tick();
        rst_i = 1'b1;
        idle();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register plus operand-forwarding and load-use hazard logic sitting directly upstream of the EX-stage ALU.
- Latches decoded operands and control from ID, then drives the ALU's A, B, ALUctl and shamt with EX/MEM and MEM/WB forwarding applied.
- Registers the destination and control bundle for the EX/MEM register.
- Detects load-use hazards and inserts bubbles; accepts branch flush.

Parameters:
DATA_W, 32, datapath width
REG_AW, 5, register-file address width
CTRL_W, 7, control-bundle width (field layout in package)

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous active-low reset
valid_i  input  1  ID slot holds a real instruction
rs_data_i  input  DATA_W  RF read data for rs
rt_data_i  input  DATA_W  RF read data for rt
imm_i  input  DATA_W  extended immediate
rs_i, rt_i, rd_i  input  REG_AW each  register addresses
shamt_i  input  5  shift amount
aluctl_i  input  4  ALU operation code
ctrl_i  input  CTRL_W  {reg_write, mem_read, mem_write, mem_to_reg, branch, alu_src, reg_dst}
flush_i  input  1  kill the instruction in ID (taken branch)
exm_we_i, exm_wa_i, exm_data_i  input  1/REG_AW/DATA_W  EX/MEM writeback candidate
wb_we_i, wb_wa_i, wb_data_i  input  1/REG_AW/DATA_W  MEM/WB writeback candidate
stall_o  output  1  hold PC and IF/ID this cycle
valid_o  output  1  EX slot valid
a_o, b_o  output  DATA_W each  ALU operands
aluctl_o  output  4  registered ALU op
shamt_o  output  5  registered shamt
wa_o  output  REG_AW  destination: reg_dst ? rd : rt
st_data_o  output  DATA_W  forwarded rt value for stores
ctrl_o  output  CTRL_W  registered control bundle

Behaviour:
- Reset (rst_i=0, async): all registers 0. valid_o=0, ctrl_o=0, aluctl_o=0, wa_o=0. a_o, b_o and st_data_o are then combinationally 0 unless forwarding hits address 0, which never happens.
- Latency: one cycle. ID inputs sampled at posedge appear on the outputs after that edge.
- Load-use hazard: stall_o = valid_i & valid_o & ctrl_o.mem_read & (ex_rt != 0) & (ex_rt == rs_i | ex_rt == rt_i); combinational. ex_rt is the registered rt.
- Stall: the register loads a bubble (valid_o=0, ctrl_o=0, aluctl_o=0). Upstream holds. Next cycle the same ID instruction re-evaluates with no hazard.
- Flush: flush_i=1 loads a bubble and forces stall_o=0 the same cycle. Flush beats stall.
- valid_i=0: loads a bubble.
- Forwarding per source register r (rs_q or rt_q), combinational on registered addresses:
  - EX/MEM value if exm_we_i & exm_wa_i != 0 & exm_wa_i == r;
  - else MEM/WB value if wb_we_i & wb_wa_i != 0 & wb_wa_i == r;
  - else the latched RF data.
  - EX/MEM has priority. Address 0 is never forwarded.
- a_o = fwd(rs_q).
- b_o = alu_src ? imm_q : fwd(rt_q).
- st_data_o = fwd(rt_q) always.
- Bubbles carry zero control, so reg_write=0 and mem_write=0 downstream.
- Reset mid-stall: stall state is lost. Upstream re-issues after reset.

Optional Feature:
ID_EX_STATS_EN
- Defined: adds stall_cnt_o and flush_cnt_o, both output 32.
  - stall_cnt_o increments on each cycle with stall_o=1.
  - flush_cnt_o increments on each cycle with flush_i=1.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Shared package/include holds:
  - ALUctl codes: AND=0, OR=1, ADD=2, SRLV=3, SRL=4, LUI=5, SUB=6, SLT=7, ORI=8, EQ=9;
  - ctrl field bit indices and CTRL_W;
  - REG_AW.
- One sub-module fwd_unit: pure-combinational priority forwarding select for a single operand, instantiated twice.
- Hazard detect stays inline.

Test Plan:
- Reset: assert rst_i=0 mid-cycle with valid data pending -> valid_o=0, ctrl_o=0 immediately, without waiting for a clock edge.
- Pass-through: add, rs_data=5, rt_data=7, no forward matches -> next cycle a_o=5, b_o=7, aluctl_o=2, valid_o=1.
- Forward priority: rs=3 in EX, exm_wa=3 with data 0xAA, wb_wa=3 with data 0xBB -> a_o=0xAA. Drop exm_we_i -> a_o=0xBB.
- Zero register: rs=0, exm_wa=0, exm_we=1, data 0xFF -> a_o equals the latched RF data, not 0xFF.
- Load-use: lw to $t1 in EX, ID uses rt=$t1 -> stall_o=1 for exactly one cycle, then a bubble (valid_o=0), then the dependent instruction issues.
- Flush vs stall: same load-use setup plus flush_i=1 -> stall_o=0, bubble loaded. With the macro defined, flush_cnt_o increments by 1 and stall_cnt_o is unchanged.
